// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for expressions made of single decimal
// digits joined by '+' and '*', with '*' binding tighter than '+'.
// It reads one ASCII character per cycle from the same bus as the
// expression recognizer. 'valid' tracks the recognizer's accept decision.
//
// Ports:
//   clk      - clock, rising edge
//   clr      - synchronous active-high reset
//   in_valid - 'in' carries a character this cycle (low = bubble, all state holds)
//   in       - ASCII character
//   result   - registered value of the expression so far (sum + current product)
//   valid    - stream so far is a complete legal expression
//   err      - sticky: an illegal character or ordering has been seen
//   ovf      - sticky arithmetic overflow flag
//
// Optional feature: define EXPR_EVAL_OVF_EN to build the overflow detector.
// Without it, ovf is tied to 0. Arithmetic wraps modulo 2^WIDTH either way.
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             err,
    output logic             ovf
);

    typedef enum logic [1:0] {
        START = 2'd0,
        OPND  = 2'd1,
        OPR   = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [WIDTH-1:0]  prod_q, prod_d;
    logic              pend_mul_q, pend_mul_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;

    logic              is_digit, is_plus, is_star;
    logic [7:0]        digit_raw;
    logic [3:0]        digit;
    logic [WIDTH-1:0]  mul_trunc;
    logic [WIDTH-1:0]  add_trunc;   // sum_q + prod_q, used when '+' folds the term
    logic [WIDTH-1:0]  res_opr;     // sum_q + new product, used on a digit after an operator
    logic [WIDTH-1:0]  prod_opr;    // product after a digit that follows an operator
    logic              mul_ovf, add_ovf, res_ovf;

    assign is_digit  = (in >= 8'h30) && (in <= 8'h39);
    assign is_plus   = (in == 8'h2B);
    assign is_star   = (in == 8'h2A);
    assign digit_raw = in - 8'h30;
    assign digit     = digit_raw[3:0];

    // The digit after an operator either extends the current product or starts a new one.
    assign prod_opr = pend_mul_q ? mul_trunc : {{(WIDTH-4){1'b0}}, digit};

`ifdef EXPR_EVAL_OVF_EN
    logic [WIDTH+3:0] mul_full;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   res_full;

    assign mul_full  = {4'b0, prod_q} * {{WIDTH{1'b0}}, digit};
    assign mul_trunc = mul_full[WIDTH-1:0];
    assign mul_ovf   = pend_mul_q && (mul_full[WIDTH+3:WIDTH] != 4'b0);

    assign add_full  = {1'b0, sum_q} + {1'b0, prod_q};
    assign add_trunc = add_full[WIDTH-1:0];
    assign add_ovf   = add_full[WIDTH];

    assign res_full  = {1'b0, sum_q} + {1'b0, prod_opr};
    assign res_opr   = res_full[WIDTH-1:0];
    assign res_ovf   = res_full[WIDTH];
`else
    assign mul_trunc = prod_q * {{(WIDTH-4){1'b0}}, digit};
    assign add_trunc = sum_q + prod_q;
    assign res_opr   = sum_q + prod_opr;
    assign mul_ovf   = 1'b0;
    assign add_ovf   = 1'b0;
    assign res_ovf   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        prod_d     = prod_q;
        pend_mul_d = pend_mul_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        if (in_valid) begin
            unique case (state_q)
                START: begin
                    if (is_digit) begin
                        sum_d    = '0;
                        prod_d   = {{(WIDTH-4){1'b0}}, digit};
                        result_d = {{(WIDTH-4){1'b0}}, digit};
                        state_d  = OPND;
                    end else begin
                        state_d  = ERR;
                    end
                end
                OPND: begin
                    if (is_plus) begin
                        sum_d      = add_trunc;
                        pend_mul_d = 1'b0;
                        ovf_d      = ovf_q | add_ovf;
                        state_d    = OPR;
                    end else if (is_star) begin
                        pend_mul_d = 1'b1;
                        state_d    = OPR;
                    end else begin
                        state_d    = ERR;
                    end
                end
                OPR: begin
                    if (is_digit) begin
                        prod_d   = prod_opr;
                        result_d = res_opr;
                        ovf_d    = ovf_q | mul_ovf | res_ovf;
                        state_d  = OPND;
                    end else begin
                        state_d  = ERR;
                    end
                end
                default: begin
                    state_d = ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= START;
            sum_q      <= '0;
            prod_q     <= '0;
            pend_mul_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            prod_q     <= prod_d;
            pend_mul_q <= pend_mul_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
        end
    end

    assign result = result_q;
    assign valid  = (state_q == OPND);
    assign err    = (state_q == ERR);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;

    localparam int W = 8;

`ifdef EXPR_EVAL_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_ch = 8'h00;
    logic [W-1:0] result;
    logic         valid, err, ovf;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic         vld;
        logic         er;
        logic         ov;
    } exp_t;

    exp_t sb[$];

    expr_eval #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in_ch),
        .result   (result),
        .valid    (valid),
        .err      (err),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Drive one cycle, record what the outputs must be after the edge, then check.
    task automatic step(input string tag, input logic [7:0] ch, input logic iv, input logic cl,
                        input logic [W-1:0] e_res, input logic e_vld, input logic e_err, input logic e_ovf);
        exp_t e;
        e.tag = tag; e.res = e_res; e.vld = e_vld; e.er = e_err; e.ov = e_ovf;
        sb.push_back(e);
        in_ch    = ch;
        in_valid = iv;
        clr      = cl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (result === e.res) else begin
                failures++;
                $error("FAIL %s.result got=%0d exp=%0d", e.tag, result, e.res);
            end
            checks++;
            assert (valid === e.vld) else begin
                failures++;
                $error("FAIL %s.valid got=%b exp=%b", e.tag, valid, e.vld);
            end
            checks++;
            assert (err === e.er) else begin
                failures++;
                $error("FAIL %s.err got=%b exp=%b", e.tag, err, e.er);
            end
            checks++;
            assert (ovf === e.ov) else begin
                failures++;
                $error("FAIL %s.ovf got=%b exp=%b", e.tag, ovf, e.ov);
            end
        end
    endtask

    initial begin
        // reset
        step("rst",      8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

        // "1+2*3" back to back
        step("t1_1",     "1",   1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        step("t1_plus",  "+",   1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        step("t1_2",     "2",   1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        step("t1_star",  "*",   1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        step("t1_3",     "3",   1'b1, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);

        // "2*3*4+5" with two bubbles between characters; bubble carries junk
        step("t2_clr",   8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t2_2",     "2",   1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        step("t2_b0",    "+",   1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        step("t2_b1",    "x",   1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        step("t2_s1",    "*",   1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        step("t2_b2",    "9",   1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        step("t2_b3",    "9",   1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        step("t2_3",     "3",   1'b1, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
        step("t2_b4",    "*",   1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
        step("t2_b5",    "*",   1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
        step("t2_s2",    "*",   1'b1, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0);
        step("t2_b6",    "1",   1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0);
        step("t2_b7",    "1",   1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0);
        step("t2_4",     "4",   1'b1, 1'b0, 8'd24, 1'b1, 1'b0, 1'b0);
        step("t2_b8",    "+",   1'b0, 1'b0, 8'd24, 1'b1, 1'b0, 1'b0);
        step("t2_b9",    "+",   1'b0, 1'b0, 8'd24, 1'b1, 1'b0, 1'b0);
        step("t2_plus",  "+",   1'b1, 1'b0, 8'd24, 1'b0, 1'b0, 1'b0);
        step("t2_b10",   "*",   1'b0, 1'b0, 8'd24, 1'b0, 1'b0, 1'b0);
        step("t2_b11",   "*",   1'b0, 1'b0, 8'd24, 1'b0, 1'b0, 1'b0);
        step("t2_5",     "5",   1'b1, 1'b0, 8'd29, 1'b1, 1'b0, 1'b0);

        // leading '+' is illegal; error absorbs the following digit
        step("t3_clr",   8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t3_plus",  "+",   1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step("t3_5",     "5",   1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

        // "7**2": error on second '*', result frozen at 7
        step("t4_clr",   8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t4_7",     "7",   1'b1, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);
        step("t4_s1",    "*",   1'b1, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
        step("t4_s2",    "*",   1'b1, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0);
        step("t4_2",     "2",   1'b1, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0);

        // two digits in a row and a non-grammar character are illegal
        step("t5_clr",   8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t5_4",     "4",   1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
        step("t5_4b",    "4",   1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0);
        step("t5_clr2",  8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t5_a",     "a",   1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

        // "9*9*9+9" at WIDTH=8: 729 mod 256 = 217, then 217+9 = 226
        step("t6_clr",   8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t6_9a",    "9",   1'b1, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
        step("t6_s1",    "*",   1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0);
        step("t6_9b",    "9",   1'b1, 1'b0, 8'd81, 1'b1, 1'b0, 1'b0);
        step("t6_s2",    "*",   1'b1, 1'b0, 8'd81, 1'b0, 1'b0, 1'b0);
        step("t6_9c",    "9",   1'b1, 1'b0, 8'd217, 1'b1, 1'b0, OVF);
        step("t6_plus",  "+",   1'b1, 1'b0, 8'd217, 1'b0, 1'b0, OVF);
        step("t6_9d",    "9",   1'b1, 1'b0, 8'd226, 1'b1, 1'b0, OVF);

        // "3+4", then clr beats an in_valid '*', then "8"
        step("t7_clr",   8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t7_3",     "3",   1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        step("t7_plus",  "+",   1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        step("t7_4",     "4",   1'b1, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);
        step("t7_clrst", "*",   1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step("t7_8",     "8",   1'b1, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
